// File: rtl/amba_pkg.sv
// amba_pkg: shared AHB/APB encodings, bridge state enum and byte-strobe helper
package amba_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam int MAX_BYTES = 16;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;
  // Byte lanes covered by a 2^hsize transfer, address aligned down to the transfer size
  function automatic logic [MAX_BYTES-1:0] size_to_strb(input logic [2:0] hsize,
                                                        input logic [3:0] offset,
                                                        input int dsize);
    int n;
    int base;
    logic [MAX_BYTES-1:0] m;
    n = 1 << hsize;
    base = (int'(offset) / n) * n;
    for (int i = 0; i < MAX_BYTES; i++) m[i] = (i >= base) && (i < base + n) && (i < (1 << dsize));
    return m;
  endfunction
endpackage

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB master, one APB SETUP/ACCESS per accepted AHB beat
module ahb2apb_bridge
  import amba_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DSIZE = 2,
  localparam int DBYTES = 1 << DSIZE,
  localparam int DWIDTH = DBYTES * 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic [3:0]        hprot,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic              hmastlock,
  input  logic              hwrite,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [DWIDTH-1:0] hwdata,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              psel,
  output logic              penable,
  output logic [2:0]        pprot,
  output logic              pwrite,
  output logic [AWIDTH-1:0] paddr,
  output logic [DBYTES-1:0] pstrb,
  output logic [DWIDTH-1:0] pwdata,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  bridge_state_e state_q, state_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic [DBYTES-1:0] pstrb_q, pstrb_d;
  logic [2:0] pprot_q, pprot_d, size_q, size_d;
  logic [DSIZE-1:0] off_q, off_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
  logic hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic accept;
  logic [MAX_BYTES-1:0] strb_full;
  logic unused_inputs;

  assign unused_inputs = ^{hburst, hmastlock, hprot[3:2], htrans[0]};
  assign accept = hsel & hready & htrans[1] & (state_q == ST_IDLE || state_q == ST_ERR2);
  assign strb_full = size_to_strb(size_q, 4'(off_q), DSIZE);

  // Next-state and datapath: latch the address phase on accept, capture write data one cycle later
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    pwrite_d = pwrite_q;
    pprot_d = pprot_q;
    size_d = size_q;
    off_d = off_q;
    pstrb_d = pstrb_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (accept) begin
      paddr_d = haddr;
      pwrite_d = hwrite;
      pprot_d = {~hprot[0], 1'b0, hprot[1]};
      size_d = hsize;
      off_d = haddr[DSIZE-1:0];
      pstrb_d = '0;
    end
    unique case (state_q)
      ST_IDLE, ST_ERR2: state_d = !accept ? ST_IDLE : hsize > 3'(DSIZE) ? ST_ERR1 : hwrite ? ST_WDATA : ST_SETUP;
      ST_WDATA: begin
        pwdata_d = hwdata;
        pstrb_d = strb_full[DBYTES-1:0];
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: if (pready) begin
        state_d = pslverr ? ST_ERR1 : ST_IDLE;
        hrdata_d = (!pslverr && !pwrite_q) ? prdata : hrdata_q;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    psel_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = state_d == ST_ACCESS;
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pprot_q <= '0;
      size_q <= '0;
      off_q <= '0;
      pstrb_q <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pprot_q <= pprot_d;
      size_q <= size_d;
      off_q <= off_d;
      pstrb_q <= pstrb_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
    end
  end

  assign psel = psel_q;
  assign penable = penable_q;
  assign pprot = pprot_q;
  assign pwrite = pwrite_q;
  assign paddr = paddr_q;
  assign pstrb = pstrb_q;
  assign pwdata = pwdata_q;
  assign hrdata = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp = hresp_q;
endmodule
